// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side control inputs and the fetch-to-decode pipeline register outputs.
interface fetch_if #(
   parameter int XLEN = 32
);
   logic            f_to_d_enable_ff;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] PC_out;
   logic            instr_valid;

   modport master (
      output imem_req_valid, imem_req_addr, instruction, PC_out, instr_valid,
      input  f_to_d_enable_ff, redirect, redirect_pc,
             imem_req_ready, imem_resp_valid, imem_resp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instruction, PC_out, instr_valid,
      output f_to_d_enable_ff, redirect, redirect_pc,
             imem_req_ready, imem_resp_valid, imem_resp_data
   );
endinterface

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding,
// and feeds decode through a stallable, flushable output register.
module fetch_cycle #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input logic    clk,
   input logic    rst,
   fetch_if.master fif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic            drop;
   logic [XLEN-1:0] hold_data;
   logic            req_valid;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_out_q;
   logic            ivld_q;

   logic            accept;
   logic            resp_new;
   logic            deliver;
   logic [XLEN-1:0] deliver_word;

   always_comb begin
      accept       = (state == S_REQ) && req_valid && fif.imem_req_ready;
      resp_new     = (state == S_WAIT) && fif.imem_resp_valid && !drop;
      deliver      = !fif.redirect && fif.f_to_d_enable_ff &&
                     (resp_new || (state == S_HOLD));
      deliver_word = (state == S_HOLD) ? hold_data : fif.imem_resp_data;
   end

   // Control FSM; req_valid is registered so it stays low throughout reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         hold_data <= '0;
         req_valid <= 1'b0;
      end else if (fif.redirect) begin
         pc        <= fif.redirect_pc & ~XLEN'(3);
         hold_data <= '0;
         case (state)
            S_REQ: begin
               if (accept) begin
                  drop      <= 1'b1;
                  state     <= S_WAIT;
                  req_valid <= 1'b0;
               end else begin
                  req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (fif.imem_resp_valid) begin
                  drop      <= 1'b0;
                  state     <= S_REQ;
                  req_valid <= 1'b1;
               end else begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state     <= S_REQ;
               req_valid <= 1'b1;
            end
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (accept) begin
                  state     <= S_WAIT;
                  req_valid <= 1'b0;
               end else begin
                  req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (fif.imem_resp_valid) begin
                  if (drop) begin
                     // Response to a request orphaned by an earlier redirect.
                     drop      <= 1'b0;
                     state     <= S_REQ;
                     req_valid <= 1'b1;
                  end else if (fif.f_to_d_enable_ff) begin
                     pc        <= pc + XLEN'(4);
                     state     <= S_REQ;
                     req_valid <= 1'b1;
                  end else begin
                     hold_data <= fif.imem_resp_data;
                     state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (fif.f_to_d_enable_ff) begin
                  pc        <= pc + XLEN'(4);
                  state     <= S_REQ;
                  req_valid <= 1'b1;
               end
            end
            default: begin
               state     <= S_REQ;
               req_valid <= 1'b1;
            end
         endcase
      end
   end

   // Fetch-to-decode register: flush beats stall, stall beats advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q  <= NOP_INSTR;
         pc_out_q <= '0;
         ivld_q   <= 1'b0;
      end else if (fif.redirect) begin
         instr_q <= NOP_INSTR;
         ivld_q  <= 1'b0;
      end else if (fif.f_to_d_enable_ff) begin
         if (deliver) begin
            instr_q  <= deliver_word;
            pc_out_q <= pc;
            ivld_q   <= 1'b1;
         end else begin
            instr_q <= NOP_INSTR;
            ivld_q  <= 1'b0;
         end
      end
   end

   assign fif.imem_req_valid = req_valid;
   assign fif.imem_req_addr  = pc;
   assign fif.instruction    = instr_q;
   assign fif.PC_out         = pc_out_q;
   assign fif.instr_valid    = ivld_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Randomized bench for fetch_cycle: a memory responder plus a program-order
// reference of expected PCs, checked by an independent output monitor.
module tb_fetch_cycle;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_if #(.XLEN(XLEN)) fif ();

   fetch_cycle #(.XLEN(XLEN), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   int n_vec = 0;
   int n_err = 0;

   // Expected program-order stream of PCs decode should see as valid.
   logic [31:0] exp_q[$];
   logic [31:0] exp_next;

   bit          outstanding = 0;
   int          cnt = 0;
   logic [31:0] out_addr = '0;

   bit          last_en = 0, last_redir = 0, last_accept = 0;
   logic [31:0] last_target = '0;

   int ready_pct = 100, en_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
   bit          rd_pend = 0;
   int          rd_when = 0;
   logic [31:0] rd_target = '0;
   int          idle = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return ((a ^ 32'hA5A5_0000) * 32'h9E37_79B1) + 32'h0000_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_next);
         exp_next = exp_next + 32'd4;
      end
   endfunction

   function automatic void retarget(input logic [31:0] t);
      exp_q.delete();
      exp_next = t & ~32'h3;
      refill();
   endfunction

   // One cycle of stimulus, driven on the falling edge.
   task automatic step();
      bit resp_now, acc, fire;
      @(negedge clk);
      resp_now = 0;
      fif.imem_resp_valid = 1'b0;
      fif.redirect        = 1'b0;
      fif.redirect_pc     = $urandom;
      if (outstanding) begin
         cnt--;
         if (cnt <= 0) begin
            fif.imem_resp_valid = 1'b1;
            fif.imem_resp_data  = mem(out_addr);
            outstanding = 0;
            resp_now    = 1;
         end
      end
      fif.imem_req_ready   = ($urandom_range(99) < ready_pct);
      fif.f_to_d_enable_ff = ($urandom_range(99) < en_pct);
      if (!rd_pend && redir_pct > 0 && $urandom_range(99) < redir_pct) begin
         rd_pend   = 1;
         rd_when   = 0;
         rd_target = $urandom;
      end
      fire = rd_pend && (rd_when == 0 ||
                         (rd_when == 1 && outstanding && !resp_now) ||
                         (rd_when == 2 && resp_now) ||
                         (rd_when == 3 && fif.imem_req_valid && !fif.imem_req_ready));
      if (fire) begin
         fif.redirect    = 1'b1;
         fif.redirect_pc = rd_target;
         rd_pend = 0;
         retarget(rd_target);
      end
      acc = fif.imem_req_valid && fif.imem_req_ready;
      if (acc) begin
         chk("one_outstanding", 32'(outstanding), 32'd0);
         outstanding = 1;
         cnt         = $urandom_range(lat_max, lat_min);
         out_addr    = fif.imem_req_addr;
      end
      last_en     = fif.f_to_d_enable_ff;
      last_redir  = fire;
      last_accept = acc;
      last_target = rd_target & ~32'h3;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      fif.redirect        = 1'b0;
      fif.imem_resp_valid = 1'b0;
      fif.imem_req_ready  = 1'b0;
      fif.f_to_d_enable_ff = 1'b1;
      fif.redirect_pc     = '0;
      fif.imem_resp_data  = '0;
      outstanding = 0;
      rd_pend     = 0;
      #1;
      chk("rst_req_valid", 32'(fif.imem_req_valid), 32'd0);
      chk("rst_instr", fif.instruction, NOP);
      chk("rst_pc_out", fif.PC_out, 32'd0);
      chk("rst_instr_valid", 32'(fif.instr_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      retarget(RESET_PC);
      last_en = 1; last_redir = 0; last_accept = 0;
      @(negedge clk);
      chk("post_rst_req_valid", 32'(fif.imem_req_valid), 32'd1);
      chk("post_rst_addr", fif.imem_req_addr, RESET_PC);
      // Stale response while in REQ must be ignored.
      fif.imem_resp_valid = 1'b1;
      fif.imem_resp_data  = 32'hBAD0_BAD0;
      fif.imem_req_ready  = 1'b0;
      last_en = 1; last_redir = 0; last_accept = 0;
   endtask

   // Output monitor: compares decode-side outputs after every rising edge.
   initial begin
      logic [31:0] p_instr, p_pc, p_addr, e;
      logic        p_iv, p_rv;
      p_instr = NOP; p_pc = '0; p_addr = '0; p_iv = 0; p_rv = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (last_redir) begin
               chk("redir_bubble_valid", 32'(fif.instr_valid), 32'd0);
               chk("redir_bubble_instr", fif.instruction, NOP);
               if (fif.imem_req_valid) chk("redir_req_addr", fif.imem_req_addr, last_target);
               idle++;
            end else if (last_en) begin
               if (fif.instr_valid) begin
                  e = exp_q.pop_front();
                  refill();
                  chk("deliver_pc", fif.PC_out, e);
                  chk("deliver_instr", fif.instruction, mem(e));
                  idle = 0;
               end else begin
                  chk("bubble_instr", fif.instruction, NOP);
                  chk("bubble_pc_hold", fif.PC_out, p_pc);
                  idle++;
               end
            end else begin
               chk("stall_instr", fif.instruction, p_instr);
               chk("stall_pc", fif.PC_out, p_pc);
               chk("stall_valid", 32'(fif.instr_valid), 32'(p_iv));
               idle++;
            end
            if (!last_redir && p_rv && !last_accept && fif.imem_req_valid)
               chk("req_addr_stable", fif.imem_req_addr, p_addr);
            if (idle > 400) begin
               n_vec++; n_err++;
               $display("FAIL progress: no instruction delivered in 400 cycles at %0t", $time);
               idle = 0;
            end
         end
         p_instr = fif.instruction; p_pc = fif.PC_out; p_iv = fif.instr_valid;
         p_rv = fif.imem_req_valid; p_addr = fif.imem_req_addr;
      end
   end

   initial begin
      do_reset();
      // Straight-line fetch, k=1, no stalls.
      repeat (30) step();
      // Stall while a word returns: word parks in the hold buffer, no new request.
      en_pct = 0;
      repeat (12) step();
      chk("hold_no_req", 32'(fif.imem_req_valid), 32'd0);
      en_pct = 100;
      repeat (10) step();
      // Redirect in WAIT before the response (k=3).
      lat_min = 3; lat_max = 3;
      rd_pend = 1; rd_when = 1; rd_target = 32'h0000_0100;
      repeat (25) step();
      chk("redir_wait_fired", 32'(rd_pend), 32'd0);
      // Redirect coincident with a response.
      lat_min = 1; lat_max = 1;
      rd_pend = 1; rd_when = 2; rd_target = 32'h0000_0203;
      repeat (20) step();
      chk("redir_resp_fired", 32'(rd_pend), 32'd0);
      // Request held unaccepted, then redirected while still pending.
      ready_pct = 0;
      repeat (4) step();
      rd_pend = 1; rd_when = 3; rd_target = 32'h0000_0040;
      step();
      chk("redir_req_fired", 32'(rd_pend), 32'd0);
      ready_pct = 100;
      repeat (15) step();
      // PC wrap at the top of the address space.
      rd_pend = 1; rd_when = 0; rd_target = 32'hFFFF_FFFC;
      repeat (20) step();
      // Reset mid-WAIT.
      lat_min = 5; lat_max = 5;
      for (int i = 0; i < 20 && !outstanding; i++) step();
      step();
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (20) step();
      // Randomized traffic.
      ready_pct = 70; en_pct = 75; redir_pct = 3; lat_min = 1; lat_max = 4;
      repeat (3000) step();
      redir_pct = 0;
      repeat (20) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
